// File: rtl/simd_accum.sv
`default_nettype none
// ============================================================================
// Module   : simd_accum
// Purpose  : Accumulates a packet of packed SIMD ALU result beats. Each beat
//            is added lane by lane (4x8, 2x16 or 1x32, signed, with no carry
//            between lanes). The add either wraps or saturates. Each byte lane
//            has a sticky overflow flag. The packet result is held until the
//            downstream handshake completes.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/in_data/in_width/in_saturate/in_last - beat in
//            out_valid/out_ready/out_data/out_flags/out_beats      - result out
// Revision : 1.0 - initial release
// ============================================================================
module simd_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_width,
  input  logic             in_saturate,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] out_beats
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_acc;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_beats;
  logic [1:0]       r_width;   // stored normalised: 3 is folded into 2
  logic             r_sat;
  logic             w_accept;

  // Candidate sums for every lane width. The captured width selects one.
  logic [31:0] w_sum8, w_sum16, w_sum32, w_sum;
  logic [3:0]  w_ovf8, w_ovf_sel;
  logic [1:0]  w_ovf16;
  logic        w_ovf32;

  // Signed overflow: both operands have the same sign, but the sum's sign differs.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane8
      logic [7:0] w_a, w_b, w_s;
      assign w_a = r_acc[8*i +: 8];
      assign w_b = in_data[8*i +: 8];
      assign w_s = w_a + w_b;
      assign w_ovf8[i] = (w_a[7] == w_b[7]) && (w_s[7] != w_a[7]);
      assign w_sum8[8*i +: 8] = (r_sat && w_ovf8[i]) ? (w_a[7] ? 8'h80 : 8'h7F) : w_s;
    end
    for (genvar i = 0; i < 2; i++) begin : g_lane16
      logic [15:0] w_a, w_b, w_s;
      assign w_a = r_acc[16*i +: 16];
      assign w_b = in_data[16*i +: 16];
      assign w_s = w_a + w_b;
      assign w_ovf16[i] = (w_a[15] == w_b[15]) && (w_s[15] != w_a[15]);
      assign w_sum16[16*i +: 16] = (r_sat && w_ovf16[i]) ?
                                   (w_a[15] ? 16'h8000 : 16'h7FFF) : w_s;
    end
  endgenerate

  logic [31:0] w_s32;
  assign w_s32   = r_acc + in_data;
  assign w_ovf32 = (r_acc[31] == in_data[31]) && (w_s32[31] != r_acc[31]);
  assign w_sum32 = (r_sat && w_ovf32) ? (r_acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : w_s32;

  always_comb begin
    w_sum     = w_sum32;
    w_ovf_sel = {4{w_ovf32}};
    case (r_width)
      2'd0: begin
        w_sum     = w_sum8;
        w_ovf_sel = w_ovf8;
      end
      2'd1: begin
        w_sum     = w_sum16;
        w_ovf_sel = {{2{w_ovf16[1]}}, {2{w_ovf16[0]}}};
      end
      default: begin
        w_sum     = w_sum32;
        w_ovf_sel = {4{w_ovf32}};
      end
    endcase
  end

  assign w_accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = in_last ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (w_accept && in_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulator datapath. A beat accepted in IDLE starts a new packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_flags <= '0;
      r_beats <= '0;
      r_width <= '0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      if (r_state == IDLE) begin
        r_acc   <= in_data;
        r_flags <= '0;
        r_beats <= CNT_W'(1);
        r_width <= (in_width == 2'd3) ? 2'd2 : in_width;
        r_sat   <= in_saturate;
      end else begin
        r_acc   <= w_sum;
        r_flags <= r_flags | w_ovf_sel;
        if (r_beats != {CNT_W{1'b1}}) r_beats <= r_beats + CNT_W'(1);
      end
    end
  end

  assign out_data  = r_acc;
  assign out_flags = r_flags;
  assign out_beats = r_beats;

endmodule
`default_nettype wire

// File: tb/tb_simd_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_accum
// Purpose  : Self-checking bench for simd_accum. The reference model works on
//            signed lane values as plain integers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_accum;

  localparam int CNT_W = 8;
  localparam int BMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_saturate, in_last;
  logic [31:0]      in_data;
  logic [1:0]       in_width;
  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] out_beats;

  always #5 clk = ~clk;

  simd_accum #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_width(in_width), .in_saturate(in_saturate), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .out_beats(out_beats)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_acc;
  logic [3:0]  m_flags;
  int          m_beats;
  logic [1:0]  m_w;
  logic        m_s;
  logic        m_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Lane-wise signed add on integers: clamp or wrap, and flag the byte lanes that overflowed.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] w, input logic s,
                                  output logic [31:0] r, output logic [3:0] f);
    int lw, nl;
    longint av, bv, sm, mx, mn, md;
    lw = (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
    nl = 32 / lw;
    md = longint'(1) << lw;
    mx = (longint'(1) << (lw - 1)) - 1;
    mn = -(longint'(1) << (lw - 1));
    r = '0;
    f = '0;
    for (int k = 0; k < nl; k++) begin
      av = longint'({32'h0, a >> (k * lw)}) & (md - 1);
      bv = longint'({32'h0, b >> (k * lw)}) & (md - 1);
      if (av > mx) av = av - md;
      if (bv > mx) bv = bv - md;
      sm = av + bv;
      if (sm > mx || sm < mn) begin
        for (int j = k * lw / 8; j < (k + 1) * lw / 8; j++) f[j] = 1'b1;
        if (s) sm = (sm > mx) ? mx : mn;
      end
      r = r | 32'((sm & (md - 1)) << (k * lw));
    end
  endfunction

  function automatic void model_beat(input logic [31:0] d, input logic [1:0] w, input logic s);
    logic [31:0] r;
    logic [3:0]  f;
    if (m_first) begin
      m_w     = (w == 2'd3) ? 2'd2 : w;
      m_s     = s;
      m_acc   = d;
      m_flags = '0;
      m_beats = 1;
      m_first = 1'b0;
    end else begin
      ref_add(m_acc, d, m_w, m_s, r, f);
      m_acc   = r;
      m_flags = m_flags | f;
      m_beats = m_beats + 1;
    end
  endfunction

  function automatic logic [31:0] exp_beats();
    return (m_beats > BMAX) ? 32'(BMAX) : 32'(m_beats);
  endfunction

  task automatic check_running(input string tag, input logic vld);
    chk({tag, "_valid"}, out_valid, vld);
    chk({tag, "_data"},  out_data,  m_acc);
    chk({tag, "_flags"}, out_flags, m_flags);
    chk({tag, "_beats"}, out_beats, exp_beats());
  endtask

  // Present a beat and clock it in. The sampling point is #1 after the edge.
  task automatic send_beat(input logic [31:0] d, input logic [1:0] w, input logic s,
                           input logic last);
    in_valid = 1'b1; in_data = d; in_width = w; in_saturate = s; in_last = last;
    chk("in_ready_pre", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(d, w, s);
    check_running("beat", last);
  endtask

  task automatic finish_pkt(input int stall);
    logic [31:0] d0;
    logic [3:0]  f0;
    logic [CNT_W-1:0] b0;
    d0 = out_data; f0 = out_flags; b0 = out_beats;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_data",  out_data, d0);
      chk("hold_flags", out_flags, f0);
      chk("hold_beats", out_beats, b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("xfer_valid", out_valid, 1'b0);
    chk("xfer_ready", in_ready, 1'b1);
    m_first = 1'b1;
  endtask

  initial begin
    int len;
    logic [1:0] w;
    logic s;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_width = '0; in_saturate = 1'b0;
    in_last = 1'b0; out_ready = 1'b0; m_first = 1'b1;
    m_acc = '0; m_flags = '0; m_beats = 0; m_w = '0; m_s = 1'b0;

    // Reset state, held across a clock edge
    @(posedge clk); #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_data",  out_data, 32'h0);
    chk("rst_flags", out_flags, 4'h0);
    chk("rst_beats", out_beats, 8'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 32-bit wrap
    send_beat(32'h7FFF_FFFF, 2'd2, 1'b0, 1'b0);
    send_beat(32'h0000_0001, 2'd2, 1'b0, 1'b1);
    chk("v33_data", out_data, 32'h8000_0000);
    chk("v33_flags", out_flags, 4'b1111);
    chk("v33_beats", out_beats, 8'd2);
    finish_pkt(0);

    // 32-bit saturate
    send_beat(32'h7FFF_FFFF, 2'd2, 1'b1, 1'b0);
    send_beat(32'h0000_0001, 2'd2, 1'b1, 1'b1);
    chk("v34_data", out_data, 32'h7FFF_FFFF);
    chk("v34_flags", out_flags, 4'b1111);
    chk("v34_beats", out_beats, 8'd2);
    finish_pkt(0);

    // 16-bit wrap; the second beat carries a different width, which must be ignored
    send_beat(32'h4000_FFFF, 2'd1, 1'b0, 1'b0);
    send_beat(32'h4000_0001, 2'd0, 1'b1, 1'b1);
    chk("v35_data", out_data, 32'h8000_0000);
    chk("v35_flags", out_flags, 4'b1100);
    finish_pkt(0);

    // 8-bit saturate, then backpressure for 3 cycles
    send_beat(32'h0000_007F, 2'd0, 1'b1, 1'b0);
    send_beat(32'h0000_0001, 2'd0, 1'b1, 1'b0);
    send_beat(32'h0000_00FF, 2'd0, 1'b1, 1'b1);
    chk("v36_data", out_data, 32'h0000_007E);
    chk("v36_flags", out_flags, 4'b0001);
    chk("v36_beats", out_beats, 8'd3);
    finish_pkt(3);

    // No beat is accepted on the HOLD->IDLE edge
    send_beat(32'h1111_1111, 2'd0, 1'b0, 1'b0);
    send_beat(32'h2222_2222, 2'd0, 1'b0, 1'b1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_A5A5; in_width = 2'd3;
    in_saturate = 1'b0; in_last = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("xe_valid", out_valid, 1'b0);
    chk("xe_data", out_data, 32'h3333_3333);
    chk("xe_beats", out_beats, 8'd2);
    m_first = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(32'hA5A5_A5A5, 2'd3, 1'b0);
    check_running("xe_next", 1'b1);
    finish_pkt(1);

    // Asynchronous reset mid-packet
    send_beat(32'h0102_0304, 2'd0, 1'b0, 1'b0);
    send_beat(32'h0102_0304, 2'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_data", out_data, 32'h0);
    chk("arst_beats", out_beats, 8'h0);
    @(posedge clk); #1;
    chk("arst_hold_data", out_data, 32'h0);
    rst = 1'b0;
    m_first = 1'b1;
    send_beat(32'h0102_0304, 2'd0, 1'b0, 1'b1);
    chk("v38_data", out_data, 32'h0102_0304);
    chk("v38_flags", out_flags, 4'h0);
    chk("v38_beats", out_beats, 8'd1);
    finish_pkt(0);

    // The beat counter saturates
    for (int i = 0; i < 300; i++) send_beat(32'h0, 2'd2, 1'b0, (i == 299));
    chk("beats_sat", out_beats, 8'hFF);
    finish_pkt(0);

    // Random packets: idle gaps, random out_ready outside HOLD, and junk width/saturate on later beats
    for (int p = 0; p < 40; p++) begin
      len = 1 + int'($urandom_range(5));
      w = 2'($urandom_range(3));
      s = 1'($urandom_range(1));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(2) == 0) begin
          out_ready = 1'($urandom_range(1));
          @(posedge clk); #1;
          out_ready = 1'b0;
          check_running("gap", 1'b0);
        end
        out_ready = 1'($urandom_range(1));
        if (b == 0) send_beat($urandom, w, s, (b == len - 1));
        else        send_beat($urandom, 2'($urandom_range(3)), 1'($urandom_range(1)),
                              (b == len - 1));
        out_ready = 1'b0;
      end
      finish_pkt(int'($urandom_range(2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/simd_accum.md
SIMD_ACCUM -- requirements
Module: simd_accum

Interface
REQ-001 Parameter: CNT_W, default 8, width of the beat counter and out_beats.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream ALU result beat valid.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_data  input  32  packed SIMD ALU result (c) to accumulate.
REQ-007 in_width  input  2  lane width: 0 = 4x8-bit, 1 = 2x16-bit, 2 = 1x32-bit; 3 is treated as 2.
REQ-008 in_saturate  input  1  1 = signed saturating add, 0 = wrap-around add.
REQ-009 in_last  input  1  marks the final beat of a packet.
REQ-010 out_valid  output  1  accumulated result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  32  packed per-lane accumulated sums.
REQ-013 out_flags  output  4  sticky per-byte-lane signed-overflow flags.
REQ-014 out_beats  output  CNT_W  number of beats in the packet, saturating at 2^CNT_W-1.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-017 A beat is accepted on a rising clk edge with in_valid=1 and in_ready=1.
REQ-018 IDLE, beat accepted: capture in_width/in_saturate for the packet; acc = in_data; flags = 0; beats = 1; go to HOLD if in_last, else ACCUM.
REQ-019 ACCUM, beat accepted: per lane, acc = acc + in_data using the captured width/saturate; beats++ (saturating); go to HOLD if in_last.
REQ-020 in_width and in_saturate on non-first beats SHALL be ignored.
REQ-021 Lane arithmetic SHALL be two's-complement signed, with no carry crossing lane boundaries.
REQ-022 On signed overflow with saturate=1, the lane SHALL clamp to +max (0x7F / 0x7FFF / 0x7FFFFFFF) or -min (0x80 / 0x8000 / 0x80000000); with saturate=0 it SHALL wrap.
REQ-023 On signed overflow in a lane, the flags for the byte lanes that lane covers SHALL be set, regardless of saturate; flags are sticky until the next packet starts.
REQ-024 Flag mapping: width 0, lane i sets flags[i]; width 1, lane 0 sets flags[1:0] and lane 1 sets flags[3:2]; width 2 sets flags[3:0].
REQ-025 In HOLD, out_valid SHALL be 1 and out_data/out_flags/out_beats SHALL be stable until the handshake completes.
REQ-026 In HOLD with out_ready=1, the result transfers and the FSM SHALL return to IDLE on that edge.
REQ-027 Latency: out_valid SHALL rise on the cycle after the in_last beat is accepted.
REQ-028 No beat is accepted on the HOLD->IDLE transfer edge; the next packet is accepted no earlier than one cycle later.
REQ-029 In IDLE and ACCUM, out_valid SHALL be 0, and out_data/out_flags/out_beats SHALL show the running values.
REQ-030 out_ready SHALL be ignored outside HOLD.

Reset
REQ-031 While rst=1, state SHALL be IDLE, and acc, flags, beats, captured width/saturate and out_valid SHALL be 0, with in_ready=1, regardless of clk.
REQ-032 rst asserted mid-packet (in ACCUM or HOLD) SHALL discard the packet; the first beat accepted after release starts a new packet.

Verification
REQ-033 width=2, sat=0, beats 0x7FFFFFFF then 0x00000001 (last) -> out_data 0x80000000, out_flags 4'b1111, out_beats 2.
REQ-034 width=2, sat=1, same beats -> out_data 0x7FFFFFFF, out_flags 4'b1111, out_beats 2.
REQ-035 width=1, sat=0, beats 0x4000FFFF then 0x40000001 (last) -> out_data 0x80000000, out_flags 4'b1100.
REQ-036 width=0, sat=1, beats 0x0000007F, 0x00000001, 0x000000FF (last) -> out_data 0x0000007E, out_flags 4'b0001, out_beats 3.
REQ-037 Backpressure: out_ready=0 for 3 cycles in HOLD -> out_valid=1, outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-038 rst pulsed after 2 beats in ACCUM -> all outputs 0 immediately; a following single-beat packet 0x01020304 (width 0, last) -> out_data 0x01020304, out_flags 0, out_beats 1.
